// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts out one byte with odd parity on device-generated clock falls, checks the
// device ACK and reports completion or error.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, START, BITS, ACK, WAIT_IDLE} state_t;

    // Line vectors: bit 0 = ps2 clock, bit 1 = ps2 data
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    filt_q, filt_d;
    logic [FW-1:0] fcnt_q [2];
    logic [FW-1:0] fcnt_d [2];
    logic          clk_prev_q;
    logic          fall_pulse;

    state_t        state_q, state_d;
    logic [8:0]    frame_q, frame_d;
    logic [3:0]    idx_q, idx_d;
    logic [31:0]   inh_q, inh_d;
    logic [31:0]   to_q, to_d;
    logic          nack_q, nack_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    // Two-flop synchronizer for both raw lines (idle level is high)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {ps2_data_in, ps2_clk_in};
            sync2_q <= sync1_q;
        end
    end

    // Glitch filter: a level change needs FILTER_LEN consecutive differing samples
    always_comb begin
        filt_d = filt_q;
        for (int unsigned i = 0; i < 2; i++) begin
            fcnt_d[i[0]] = '0;
            if (sync2_q[i[0]] != filt_q[i[0]]) begin
                if (fcnt_q[i[0]] == FW'(FILTER_LEN - 1)) begin
                    filt_d[i[0]] = sync2_q[i[0]];
                end else begin
                    fcnt_d[i[0]] = fcnt_q[i[0]] + FW'(1);
                end
            end
        end
    end

    // Filter state and previous filtered clock for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q     <= '1;
            fcnt_q[0]  <= '0;
            fcnt_q[1]  <= '0;
            clk_prev_q <= 1'b1;
        end else begin
            filt_q     <= filt_d;
            fcnt_q[0]  <= fcnt_d[0];
            fcnt_q[1]  <= fcnt_d[1];
            clk_prev_q <= filt_q[0];
        end
    end

    assign fall_pulse = clk_prev_q & ~filt_q[0];

    // FSM and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            idx_q     <= '0;
            inh_q     <= '0;
            to_q      <= '0;
            nack_q    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            idx_q     <= idx_d;
            inh_q     <= inh_d;
            to_q      <= to_d;
            nack_q    <= nack_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state, frame sequencing and timeout abort
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        idx_d     = idx_q;
        inh_d     = inh_q;
        to_d      = to_q;
        nack_d    = nack_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                nack_d    = 1'b0;
                if (tx_start) begin
                    frame_d  = {~^tx_data, tx_data};
                    inh_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                inh_d = inh_q + 32'd1;
                if (inh_q + 32'd2 >= INHIBIT_CYCLES) data_oe_d = 1'b1;
                if (inh_q + 32'd1 >= INHIBIT_CYCLES) begin
                    clk_oe_d = 1'b0;
                    to_d     = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (fall_pulse) begin
                    data_oe_d = ~frame_q[0];
                    idx_d     = 4'd1;
                    state_d   = BITS;
                end
            end
            BITS: begin
                if (fall_pulse) begin
                    if (idx_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end else begin
                        data_oe_d = ~frame_q[idx_q];
                        idx_d     = idx_q + 4'd1;
                    end
                end
            end
            ACK: begin
                if (fall_pulse) begin
                    nack_d  = filt_q[1];
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (&filt_q) begin
                    done_d  = ~nack_q;
                    err_d   = nack_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Normal completion in WAIT_IDLE takes precedence over a coincident timeout
        if (state_q inside {START, BITS, ACK, WAIT_IDLE}) begin
            to_d = fall_pulse ? '0 : to_q + 32'd1;
            if (state_d != IDLE && !fall_pulse && (to_q + 32'd1 >= TIMEOUT_CYCLES)) begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                done_d    = 1'b0;
                err_d     = 1'b1;
                state_d   = IDLE;
            end
        end
    end

    assign busy_d      = (state_d != IDLE);
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign tx_error    = err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-collector device model.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TO  = 500;
    localparam int FL  = 4;
    localparam int H   = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_busy, tx_done, tx_error;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       clk_line, data_line;

    assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign data_line = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN(FL)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_error(tx_error),
        .ps2_clk_in(clk_line),
        .ps2_data_in(data_line),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    typedef struct {
        logic        done;
        logic [10:0] frame;
        bit          chk_frame;
    } exp_t;

    typedef struct {
        logic [7:0]  d;
        logic [10:0] fr;
        bit          ack;
        int          glitch;
    } vec_t;

    exp_t        sb[$];
    logic [10:0] cap_frame = '0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected outcome whenever the DUT pulses done or error
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && (tx_done || tx_error)) begin
                chk("done_err_exclusive", 32'(tx_done & tx_error), 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 32'({tx_done, tx_error}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("outcome_done", 32'(tx_done), 32'(e.done));
                    chk("outcome_error", 32'(tx_error), 32'(!e.done));
                    if (e.chk_frame) chk("frame", 32'(cap_frame), 32'(e.frame));
                    chk("busy_at_end", 32'(tx_busy), 32'd0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        chk("busy_after_accept", 32'(tx_busy), 32'd1);
    endtask

    // Device model: times the inhibit, then clocks nedges falls, sampling data on rises
    task automatic dev_xfer(input int nedges, input bit ack, input int glitch_after);
        int n;
        n = 0;
        while (!ps2_clk_oe && n < 100) begin @(negedge clk); n++; end
        chk("inhibit_seen", 32'(ps2_clk_oe), 32'd1);
        if (!ps2_clk_oe) return;
        n = 0;
        while (ps2_clk_oe && n < INH + 100) begin @(negedge clk); n++; end
        chk("inhibit_len", 32'(n), 32'(INH));
        chk("start_data_low", 32'(ps2_data_oe), 32'd1);
        if (nedges == 0) begin
            n = 0;
            while (!tx_error && n < TO + 50) begin @(negedge clk); n++; end
            chk("timeout_len", 32'(n), 32'(TO));
            chk("timeout_release", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
            return;
        end
        repeat (H) @(negedge clk);
        cap_frame    = '0;
        cap_frame[0] = data_line;
        // A start request while busy must be dropped
        tx_data  = ~tx_data;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        for (int k = 1; k <= nedges; k++) begin
            if (k == 11 && ack) begin
                dev_data_low = 1'b1;
                repeat (H) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k <= 10) cap_frame[k] = data_line;
            repeat (H) @(negedge clk);
            if (k == glitch_after) begin
                dev_clk_low = 1'b1;
                repeat (2) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (H) @(negedge clk);
            end
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (tx_busy && n < 300) begin @(negedge clk); n++; end
        chk("return_idle", 32'(tx_busy), 32'd0);
    endtask

    initial begin
        vec_t vecs[5];
        exp_t e;
        vecs = '{
            '{8'hED, 11'b11111011010, 1'b1, 0},
            '{8'h01, 11'b10000000010, 1'b1, 0},
            '{8'hFF, 11'b11111111110, 1'b0, 0},
            '{8'h00, 11'b11000000000, 1'b1, 3},
            '{8'hF4, 11'b10111101000, 1'b1, 0}
        };

        repeat (4) @(negedge clk);
        chk("reset_outputs", 32'({ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error}), 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        foreach (vecs[i]) begin
            e.done = vecs[i].ack;
            e.frame = vecs[i].fr;
            e.chk_frame = 1'b1;
            sb.push_back(e);
            send(vecs[i].d);
            dev_xfer(11, vecs[i].ack, vecs[i].glitch);
            wait_idle();
        end

        // Device never clocks: timeout abort
        e.done = 1'b0;
        e.frame = '0;
        e.chk_frame = 1'b0;
        sb.push_back(e);
        send(8'hA5);
        dev_xfer(0, 1'b0, 0);
        wait_idle();

        // Reset after the fifth data bit: no completion pulse expected
        send(8'h3C);
        dev_xfer(5, 1'b0, 0);
        #2 rst = 1'b0;
        #1;
        chk("midframe_reset", 32'({ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        e.done = 1'b1;
        e.frame = 11'b11111011010;
        e.chk_frame = 1'b1;
        sb.push_back(e);
        send(8'hED);
        dev_xfer(11, 1'b1, 0);
        wait_idle();

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
